// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-code sequencer: instruction register
// field positions, the idle ROM address, FSM states and the default FIFO
// entry layout.
package micro_seq_pkg;

  // Register fields inside a decoded instruction
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // Default widths of the sequencer
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_CNT_W   = 3;
  localparam int DEF_META_W  = 17;

  // ROM address presented while nothing is being issued
  localparam logic [DEF_ADDR_W-1:0] NOP_ADDR = '1;

  typedef enum logic {IDLE, RUN} state_t;

  // One buffered instruction in the default configuration; the top module
  // declares the same layout sized from its own parameters
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  uaddr;
    logic [DEF_CNT_W-1:0]   ucnt;
    logic [DEF_META_W-1:0]  meta;
  } fifo_entry_t;

endpackage

// File: rtl/ucode_conflict_chk.sv
// Decides whether the FIFO head's single micro-op may ride along with the
// micro-op currently issuing: the two ROM words must not overlap and the
// head must not read the register the current instruction writes.
module ucode_conflict_chk #(
  parameter int UCODE_W = 32
) (
  input  logic [UCODE_W-1:0] ucode_data,
  input  logic [UCODE_W-1:0] spec_data,
  input  logic [4:0]         cur_rd,
  input  logic [4:0]         head_rs1,
  input  logic [4:0]         head_rs2,
  output logic               no_conflict
);

  logic words_disjoint;
  logic regs_free;

  // Register x0 never creates a hazard, so a zero destination always passes
  always_comb begin
    words_disjoint = (ucode_data & spec_data) == '0;
    regs_free      = (cur_rd == 5'd0) || ((cur_rd != head_rs1) && (cur_rd != head_rs2));
    no_conflict    = words_disjoint && regs_free;
  end

endmodule

// File: rtl/micro_seq_cu_p.sv
// Micro-code sequencer between decode and ALU. Decoded instructions queue
// in a DEPTH-entry FIFO; the running one steps its ROM address once per
// un-stalled cycle and hands over to the next without a bubble.
// Optional feature: define MICRO_SEQ_FUSE_EN to fuse a non-conflicting
// single-micro-op successor into the micro-op currently issuing.
module micro_seq_cu_p
  import micro_seq_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 8,
  parameter int UCODE_W = 32,
  parameter int CNT_W   = 3,
  parameter int META_W  = 17,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_uaddr,
  input  logic [CNT_W-1:0]   in_ucnt,
  input  logic [META_W-1:0]  in_meta,
  output logic [ADDR_W-1:0]  ucode_addr,
  input  logic [UCODE_W-1:0] ucode_data,
  output logic [ADDR_W-1:0]  spec_addr,
  input  logic [UCODE_W-1:0] spec_data,
  input  logic               alu_stall,
  output logic               out_valid,
  output logic [UCODE_W-1:0] out_ucode,
  output logic [INSTR_W-1:0] out_instr,
  output logic [META_W-1:0]  out_meta,
  output logic               fuse_hit
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  uaddr;
    logic [CNT_W-1:0]   ucnt;
    logic [META_W-1:0]  meta;
  } entry_t;

  entry_t             fifo_mem [DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  entry_t             head;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [META_W-1:0]  meta_nxt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign in_ready  = !full;
  assign push      = in_valid && !full && !flush && !rst;
  assign out_valid = (state == RUN);
  assign out_ucode = fuse_hit ? (ucode_data | spec_data) : ucode_data;

`ifdef MICRO_SEQ_FUSE_EN
  logic no_conflict;

  ucode_conflict_chk #(
    .UCODE_W (UCODE_W)
  ) u_conflict_chk (
    .ucode_data  (ucode_data),
    .spec_data   (spec_data),
    .cur_rd      (out_instr[RD_MSB:RD_LSB]),
    .head_rs1    (head.instr[RS1_MSB:RS1_LSB]),
    .head_rs2    (head.instr[RS2_MSB:RS2_LSB]),
    .no_conflict (no_conflict)
  );

  assign spec_addr = empty ? '1 : head.uaddr;
  assign fuse_hit  = (state == RUN) && !alu_stall && !empty &&
                     (head.ucnt == '0) && no_conflict;
`else
  logic unused_spec;

  assign unused_spec = ^spec_data;
  assign spec_addr   = '1;
  assign fuse_hit    = 1'b0;
`endif

  // Next-state logic: pick the next ROM address and decide when the FIFO head is consumed
  always_comb begin
    state_nxt = state;
    addr_nxt  = ucode_addr;
    cnt_nxt   = cnt;
    instr_nxt = out_instr;
    meta_nxt  = out_meta;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = RUN;
          addr_nxt  = head.uaddr;
          cnt_nxt   = head.ucnt;
          instr_nxt = head.instr;
          meta_nxt  = head.meta;
        end
      end
      RUN: begin
        if (!alu_stall) begin
          if (cnt != '0) begin
            addr_nxt = ucode_addr + 1'b1;
            cnt_nxt  = cnt - 1'b1;
            pop      = fuse_hit;
          end else if (fuse_hit) begin
            pop       = 1'b1;
            state_nxt = IDLE;
            addr_nxt  = '1;
          end else if (!empty) begin
            pop       = 1'b1;
            addr_nxt  = head.uaddr;
            cnt_nxt   = head.ucnt;
            instr_nxt = head.instr;
            meta_nxt  = head.meta;
          end else begin
            state_nxt = IDLE;
            addr_nxt  = '1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '1;
      end
    endcase
  end

  // State, current-instruction and FIFO pointer registers; flush empties everything but keeps the last instr/meta
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ucode_addr <= '1;
      cnt        <= '0;
      out_instr  <= '0;
      out_meta   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (flush) begin
      state      <= IDLE;
      ucode_addr <= '1;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      ucode_addr <= addr_nxt;
      cnt        <= cnt_nxt;
      out_instr  <= instr_nxt;
      out_meta   <= meta_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage needs no reset; the pointers alone decide which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{instr: in_instr, uaddr: in_uaddr,
                                       ucnt: in_ucnt, meta: in_meta};
    end
  end

endmodule

// File: tb/tb_micro_seq_cu_p.sv
// Self-checking bench for micro_seq_cu_p: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_micro_seq_cu_p;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_uaddr;
  logic [2:0]  in_ucnt;
  logic [16:0] in_meta;
  logic [7:0]  ucode_addr;
  logic [31:0] ucode_data;
  logic [7:0]  spec_addr;
  logic [31:0] spec_data;
  logic        alu_stall;
  logic        out_valid;
  logic [31:0] out_ucode;
  logic [31:0] out_instr;
  logic [16:0] out_meta;
  logic        fuse_hit;

  logic [31:0] rom [256];

  assign ucode_data = rom[ucode_addr];
  assign spec_data  = rom[spec_addr];

  always #5 clk = ~clk;

  micro_seq_cu_p #(
    .INSTR_W(32), .ADDR_W(8), .UCODE_W(32), .CNT_W(3), .META_W(17), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_uaddr(in_uaddr), .in_ucnt(in_ucnt), .in_meta(in_meta),
    .ucode_addr(ucode_addr), .ucode_data(ucode_data),
    .spec_addr(spec_addr), .spec_data(spec_data),
    .alu_stall(alu_stall), .out_valid(out_valid), .out_ucode(out_ucode),
    .out_instr(out_instr), .out_meta(out_meta), .fuse_hit(fuse_hit)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  uaddr;
    logic [2:0]  ucnt;
    logic [16:0] meta;
  } ent_t;

  // Behavioural model: a queue of waiting instructions and the one in flight
  ent_t        m_q[$];
  bit          m_active;
  logic [7:0]  m_addr;
  int          m_rem;
  logic [31:0] m_instr;
  logic [16:0] m_meta;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] exp_addr();
    return m_active ? m_addr : 8'hFF;
  endfunction

  function automatic bit m_fuse();
`ifdef MICRO_SEQ_FUSE_EN
    logic [4:0] rd;
    if (!m_active || alu_stall || m_q.size() == 0) return 1'b0;
    if (m_q[0].ucnt != 3'd0) return 1'b0;
    if ((rom[m_addr] & rom[m_q[0].uaddr]) != 32'd0) return 1'b0;
    rd = m_instr[11:7];
    if (rd != 5'd0 && (rd == m_q[0].instr[19:15] || rd == m_q[0].instr[24:20])) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_spec_addr();
`ifdef MICRO_SEQ_FUSE_EN
    return (m_q.size() > 0) ? m_q[0].uaddr : 8'hFF;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [31:0] exp_ucode();
    logic [31:0] w;
    w = rom[m_addr];
    if (m_fuse()) w = w | rom[m_q[0].uaddr];
    return w;
  endfunction

  task automatic m_load();
    ent_t e;
    e = m_q.pop_front();
    m_active = 1'b1;
    m_addr   = e.uaddr;
    m_rem    = int'(e.ucnt);
    m_instr  = e.instr;
    m_meta   = e.meta;
  endtask

  // Advance DUT and model across one rising edge
  task automatic tick();
    bit   fz;
    bit   do_push;
    ent_t e;
    ent_t dropped;
    fz      = m_fuse();
    do_push = in_valid && (m_q.size() < DEPTH);
    e.instr = in_instr;
    e.uaddr = in_uaddr;
    e.ucnt  = in_ucnt;
    e.meta  = in_meta;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_instr  = '0;
      m_meta   = '0;
    end else if (flush) begin
      m_q.delete();
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        if (m_q.size() > 0) m_load();
      end else if (!alu_stall) begin
        if (m_rem > 0) begin
          m_addr = m_addr + 8'd1;
          m_rem  = m_rem - 1;
          if (fz) dropped = m_q.pop_front();
        end else if (fz) begin
          dropped  = m_q.pop_front();
          m_active = 1'b0;
        end else if (m_q.size() > 0) begin
          m_load();
        end else begin
          m_active = 1'b0;
        end
      end
      if (do_push) m_q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [7:0] ua,
                       input logic [2:0] uc, input bit st, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_uaddr  = ua;
    in_ucnt   = uc;
    in_meta   = 17'($urandom);
    alu_stall = st;
    flush     = fl;
    #1;
  endtask

  task automatic settle();
    int k;
    drive(0, 0, 0, 0, 0, 0);
    k = 0;
    while ((m_active || m_q.size() > 0) && k < 64) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 64) begin
      n_fail++;
      $display("[TB] FAIL settle: still busy after %0d cycles, required idle", k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ucode_addr !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_ucode_addr: got %h expected ff", ucode_addr); end
    n_cmp++; if (out_instr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_out_instr: got %h expected 0", out_instr); end
    n_cmp++; if (out_meta !== 17'd0) begin n_fail++; $display("[TB] FAIL reset_out_meta: got %h expected 0", out_meta); end
    n_cmp++; if (fuse_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fuse_hit: got %b expected 0", fuse_hit); end
  endtask

  task automatic test_single();
    logic [7:0]  ea [3];
    logic [31:0] ia;
    ea[0] = 8'h10; ea[1] = 8'h11; ea[2] = 8'h12;
    ia = $urandom;
    drive(1, ia, 8'h10, 3'd2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_latency: out_valid got %b expected 0", out_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || ucode_addr !== ea[i]) begin n_fail++; $display("[TB] FAIL single_addr%0d: got v=%b %h expected v=1 %h", i, out_valid, ucode_addr, ea[i]); end
      n_cmp++; if (out_instr !== ia) begin n_fail++; $display("[TB] FAIL single_instr%0d: got %h expected %h", i, out_instr, ia); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || ucode_addr !== 8'hFF) begin n_fail++; $display("[TB] FAIL single_end: got v=%b %h expected v=0 ff", out_valid, ucode_addr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ea [3];
    logic [31:0] ei [3];
    logic [31:0] ia, ib;
    ia = $urandom; ib = $urandom;
    ea[0] = 8'h10; ea[1] = 8'h11; ea[2] = 8'h20;
    ei[0] = ia;    ei[1] = ia;    ei[2] = ib;
    drive(1, ia, 8'h10, 3'd1, 0, 0);
    tick();
    drive(1, ib, 8'h20, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || ucode_addr !== ea[i]) begin n_fail++; $display("[TB] FAIL b2b_addr%0d: got v=%b %h expected v=1 %h", i, out_valid, ucode_addr, ea[i]); end
      n_cmp++; if (out_instr !== ei[i]) begin n_fail++; $display("[TB] FAIL b2b_instr%0d: got %h expected %h", i, out_instr, ei[i]); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_end: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] ea [3];
    drive(1, $urandom, 8'h10, 3'd2, 0, 0);
    tick();
    drive(1, $urandom, 8'h40, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      n_cmp++; if (out_valid !== 1'b1 || ucode_addr !== 8'h11) begin n_fail++; $display("[TB] FAIL stall_hold%0d: got v=%b %h expected v=1 11", i, out_valid, ucode_addr); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    ea[0] = 8'h11; ea[1] = 8'h12; ea[2] = 8'h40;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || ucode_addr !== ea[i]) begin n_fail++; $display("[TB] FAIL stall_resume%0d: got v=%b %h expected v=1 %h", i, out_valid, ucode_addr, ea[i]); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_end: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_full();
    int waited;
    drive(1, $urandom, 8'h60, 3'd7, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, $urandom, 8'(8'h70 + 8'(k * 16)), 3'd0, 0, 0);
      tick();
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b expected 0", in_ready); end
    drive(1, $urandom, 8'hC8, 3'd0, 0, 0);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      n_cmp++; if (ucode_addr !== exp_addr()) begin n_fail++; $display("[TB] FAIL full_run: got %h expected %h", ucode_addr, exp_addr()); end
      tick();
      waited++;
    end
    n_cmp++; if (in_ready !== 1'b1 || ucode_addr !== 8'h70 || waited != 5) begin n_fail++; $display("[TB] FAIL full_release: ready=%b addr=%h waited=%0d expected ready=1 addr=70 waited=5", in_ready, ucode_addr, waited); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (out_valid !== m_active || ucode_addr !== exp_addr()) begin n_fail++; $display("[TB] FAIL full_drain%0d: got v=%b %h expected v=%b %h", i, out_valid, ucode_addr, m_active, exp_addr()); end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1, $urandom, 8'h30, 3'd3, 0, 0);
    tick();
    drive(1, $urandom, 8'h50, 3'd0, 0, 0);
    tick();
    drive(1, $urandom, 8'h58, 3'd0, 0, 0);
    tick();
    n_cmp++; if (ucode_addr !== 8'h31) begin n_fail++; $display("[TB] FAIL flush_pre: got %h expected 31", ucode_addr); end
    drive(1, $urandom, 8'h5C, 3'd0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0 || ucode_addr !== 8'hFF || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_now: got v=%b %h rdy=%b expected v=0 ff rdy=1", out_valid, ucode_addr, in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty%0d: out_valid got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_fuse();
    logic [31:0] ia, ib;
    ia = 32'd0; ia[11:7] = 5'd5;
    ib = 32'd0; ib[11:7] = 5'd1; ib[19:15] = 5'd6; ib[24:20] = 5'd7;
    rom[8'h40] = 32'h0000_000F;
    rom[8'h41] = 32'h0000_0100;
    rom[8'h50] = 32'h0000_00F0;
    drive(1, ia, 8'h40, 3'd1, 0, 0);
    tick();
    drive(1, ib, 8'h50, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef MICRO_SEQ_FUSE_EN
    n_cmp++; if (fuse_hit !== 1'b1 || out_ucode !== 32'hFF) begin n_fail++; $display("[TB] FAIL fuse_hit: got hit=%b %h expected hit=1 ff", fuse_hit, out_ucode); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || ucode_addr !== 8'h41 || fuse_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fuse_next: got v=%b %h hit=%b expected v=1 41 hit=0", out_valid, ucode_addr, fuse_hit); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fuse_popped: out_valid got %b expected 0", out_valid); end
    ib[19:15] = 5'd5;
    drive(1, ia, 8'h40, 3'd1, 0, 0);
    tick();
    drive(1, ib, 8'h50, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (fuse_hit !== 1'b0 || out_ucode !== 32'h0F) begin n_fail++; $display("[TB] FAIL fuse_conflict: got hit=%b %h expected hit=0 0f", fuse_hit, out_ucode); end
    tick();
    tick();
    n_cmp++; if (ucode_addr !== 8'h50 || out_instr !== ib) begin n_fail++; $display("[TB] FAIL fuse_separate: got %h %h expected 50 %h", ucode_addr, out_instr, ib); end
`else
    n_cmp++; if (fuse_hit !== 1'b0 || spec_addr !== 8'hFF || out_ucode !== 32'h0F) begin n_fail++; $display("[TB] FAIL nofuse: got hit=%b spec=%h %h expected hit=0 ff 0f", fuse_hit, spec_addr, out_ucode); end
    tick();
    tick();
    n_cmp++; if (ucode_addr !== 8'h50 || out_instr !== ib) begin n_fail++; $display("[TB] FAIL nofuse_separate: got %h %h expected 50 %h", ucode_addr, out_instr, ib); end
`endif
    settle();
  endtask

  task automatic test_random();
    bit         v, st, fl;
    logic [7:0] ua;
    for (int i = 0; i < 256; i++) rom[i] = 32'd1 << $urandom_range(0, 31);
    for (int c = 0; c < 500; c++) begin
      v  = $urandom_range(0, 99) < 60;
      st = $urandom_range(0, 99) < 20;
      fl = $urandom_range(0, 99) < 3;
      ua = ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom);
      rst = (c == 250);
      drive(v, $urandom, ua, 3'($urandom_range(0, 3)), st, fl);
      n_cmp++; if (in_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, m_q.size() < DEPTH); end
      n_cmp++; if (out_valid !== m_active) begin n_fail++; $display("[TB] FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, m_active); end
      n_cmp++; if (ucode_addr !== exp_addr()) begin n_fail++; $display("[TB] FAIL rnd_addr c=%0d: got %h expected %h", c, ucode_addr, exp_addr()); end
      n_cmp++; if (fuse_hit !== m_fuse()) begin n_fail++; $display("[TB] FAIL rnd_fuse c=%0d: got %b expected %b", c, fuse_hit, m_fuse()); end
      n_cmp++; if (spec_addr !== exp_spec_addr()) begin n_fail++; $display("[TB] FAIL rnd_spec c=%0d: got %h expected %h", c, spec_addr, exp_spec_addr()); end
      if (m_active || c == 251) begin
        n_cmp++; if (out_instr !== m_instr || out_meta !== m_meta) begin n_fail++; $display("[TB] FAIL rnd_owner c=%0d: got %h/%h expected %h/%h", c, out_instr, out_meta, m_instr, m_meta); end
      end
      if (m_active) begin
        n_cmp++; if (out_ucode !== exp_ucode()) begin n_fail++; $display("[TB] FAIL rnd_ucode c=%0d: got %h expected %h", c, out_ucode, exp_ucode()); end
      end
      tick();
    end
    rst = 1'b0;
    settle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    m_active = 1'b0;
    m_instr  = '0;
    m_meta   = '0;
    m_addr   = 8'hFF;
    m_rem    = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_full();
    test_flush();
    test_fuse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
